// File: rtl/aircraft_light_seq_if.sv
// Control/status bundle between a lighting controller and the light sequencer.
interface aircraft_light_seq_if #(
  parameter int unsigned NUM_CH = 4,
  parameter int unsigned PH_W   = 3
);
  logic                     enable;
  logic                     lamp_test;
  logic [2*NUM_CH-1:0]      mode;
  logic [PH_W*NUM_CH-1:0]   phase;
  logic [NUM_CH-1:0]        out;
  logic                     frame_start;

  modport master (
    output enable, lamp_test, mode, phase,
    input  out, frame_start
  );

  modport slave (
    input  enable, lamp_test, mode, phase,
    output out, frame_start
  );
endinterface

// File: rtl/aircraft_light_seq.sv
// Multi-channel aircraft lighting sequencer (nav, beacon, strobe, logo).
// A prescaler divides sys_clk into step ticks; a frame is PERIOD_TICKS steps.
// Per-channel mode/phase are shadowed at each frame boundary so that changes
// only take effect on the next frame. All outputs are registered.
module aircraft_light_seq #(
  parameter int unsigned NUM_CH       = 4,
  parameter int unsigned TICK_DIV     = 10_000_000,
  parameter int unsigned PERIOD_TICKS = 8
) (
  input  logic                  sys_clk,
  input  logic                  rst_n,
  aircraft_light_seq_if.slave   bus
);

  localparam int unsigned PH_W = $clog2(PERIOD_TICKS);
  localparam int unsigned PR_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PR_W-1:0] PRESC_MAX = PR_W'(TICK_DIV - 1);
  localparam logic [PH_W-1:0] STEP_MAX  = PH_W'(PERIOD_TICKS - 1);
  localparam logic [PH_W-1:0] HALF      = PH_W'(PERIOD_TICKS / 2);
  localparam logic [PH_W-1:0] FLASH2    = PH_W'(2);

  typedef enum logic {
    S_IDLE,
    S_RUN
  } state_t;

  state_t                    state_q;
  logic [PR_W-1:0]           presc_q;
  logic [PH_W-1:0]           step_q;
  logic [2*NUM_CH-1:0]       mode_sh_q;
  logic [PH_W*NUM_CH-1:0]    phase_sh_q;
  logic [NUM_CH-1:0]         out_q;
  logic                      frame_start_q;
  logic [NUM_CH-1:0]         pat_d;

  // Light decision for one channel given its mode and local step.
  function automatic logic light_on(input logic [1:0] m, input logic [PH_W-1:0] ls);
    case (m)
      2'b00:   light_on = 1'b0;
      2'b01:   light_on = 1'b1;
      2'b10:   light_on = (ls < HALF);
      default: light_on = (ls == '0) || (ls == FLASH2);
    endcase
  endfunction

  // Pattern for the current step from the shadowed per-channel settings.
  always_comb begin
    pat_d = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      pat_d[i] = light_on(mode_sh_q[2*i +: 2],
                          PH_W'(step_q + phase_sh_q[PH_W*i +: PH_W]));
    end
  end

  // Sequencer FSM: prescaler, step counter, shadow reload and output registers.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      presc_q       <= '0;
      step_q        <= '0;
      mode_sh_q     <= '0;
      phase_sh_q    <= '0;
      out_q         <= '0;
      frame_start_q <= 1'b0;
    end else begin
      frame_start_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          presc_q <= '0;
          step_q  <= '0;
          out_q   <= bus.lamp_test ? '1 : '0;
          if (bus.enable) begin
            state_q       <= S_RUN;
            mode_sh_q     <= bus.mode;
            phase_sh_q    <= bus.phase;
            frame_start_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (!bus.enable) begin
            state_q <= S_IDLE;
            presc_q <= '0;
            step_q  <= '0;
            out_q   <= bus.lamp_test ? '1 : '0;
          end else begin
            out_q <= bus.lamp_test ? '1 : pat_d;
            if (presc_q == PRESC_MAX) begin
              presc_q <= '0;
              step_q  <= step_q + 1'b1;
              // Step wraps to 0 on this edge: reload shadows together with it
              // so frame_start and the new settings both line up with step 0.
              if (step_q == STEP_MAX) begin
                mode_sh_q     <= bus.mode;
                phase_sh_q    <= bus.phase;
                frame_start_q <= 1'b1;
              end
            end else begin
              presc_q <= presc_q + 1'b1;
            end
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.out         = out_q;
  assign bus.frame_start = frame_start_q;

endmodule

// File: tb/tb_aircraft_light_seq.sv
// Directed bench for aircraft_light_seq with TICK_DIV=4, PERIOD_TICKS=8, NUM_CH=4.
// Step tables hold the expected out nibble per step, step 0 in bits [3:0].
module tb_aircraft_light_seq;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  aircraft_light_seq_if #(.NUM_CH(4), .PH_W(3)) bus ();

  aircraft_light_seq #(
    .NUM_CH       (4),
    .TICK_DIV     (4),
    .PERIOD_TICKS (8)
  ) dut (
    .sys_clk (clk),
    .rst_n   (rst_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [3:0] exp_out, input logic exp_fs);
    total++;
    assert (bus.out === exp_out) else begin
      bad++;
      $error("FAIL %s out: got %h want %h", tag, bus.out, exp_out);
    end
    total++;
    assert (bus.frame_start === exp_fs) else begin
      bad++;
      $error("FAIL %s frame_start: got %b want %b", tag, bus.frame_start, exp_fs);
    end
  endtask

  task automatic edge_chk(input string tag, input logic [3:0] exp_out, input logic exp_fs);
    @(posedge clk);
    #1;
    chk(tag, exp_out, exp_fs);
  endtask

  // Checks the 32 edges following a frame_start edge. Optional lamp_test pulse
  // raised after edge lamp_at (3 cycles) and mode/phase change after edge chg_at.
  task automatic run_frame(input string tag, input logic [31:0] tbl,
                           input int lamp_at, input int chg_at,
                           input logic [7:0] nmode, input logic [11:0] nphase);
    logic [3:0] e;
    for (int j = 1; j <= 32; j++) begin
      e = tbl[4*((j-1)/4) +: 4];
      if (lamp_at != 0 && j > lamp_at && j <= lamp_at + 3) e = 4'hF;
      edge_chk(tag, e, (j == 32));
      if (lamp_at != 0 && j == lamp_at) bus.lamp_test = 1'b1;
      if (lamp_at != 0 && j == lamp_at + 3) bus.lamp_test = 1'b0;
      if (chg_at != 0 && j == chg_at) begin
        bus.mode  = nmode;
        bus.phase = nphase;
      end
    end
  endtask

  initial begin
    logic [31:0] tbl_a0;
    logic [3:0]  e;
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.enable    = 1'b0;
    bus.lamp_test = 1'b0;
    bus.mode      = 8'h00;
    bus.phase     = 12'h000;

    repeat (2) @(posedge clk);
    #1;
    chk("reset", 4'h0, 1'b0);
    rst_n = 1'b1;

    edge_chk("idle0", 4'h0, 1'b0);
    edge_chk("idle1", 4'h0, 1'b0);

    bus.lamp_test = 1'b1;
    edge_chk("idle_lamp0", 4'hF, 1'b0);
    edge_chk("idle_lamp1", 4'hF, 1'b0);
    edge_chk("idle_lamp2", 4'hF, 1'b0);
    bus.lamp_test = 1'b0;
    edge_chk("idle_lamp_off", 4'h0, 1'b0);

    // ch3 DOUBLE, ch2 BLINK, ch1 STEADY, ch0 OFF, all phase 0.
    bus.mode   = 8'b11_10_01_00;
    bus.phase  = 12'h000;
    bus.enable = 1'b1;
    edge_chk("start", 4'h0, 1'b1);

    run_frame("f1_basic", 32'h2222_6E6E, 0, 0, 8'h00, 12'h000);
    // lamp pulse mid-run; ch1 switched to OFF during step 3 (lands next frame).
    run_frame("f2_lamp_chg", 32'h2222_6E6E, 9, 13, 8'b11_10_00_00, 12'h000);
    // ch3 BLINK phase 0, ch2 BLINK phase 4: complementary pair next frame.
    run_frame("f3_ch1off", 32'h0000_4C4C, 0, 20, 8'b10_10_00_00, 12'h100);
    run_frame("f4_compl", 32'h4444_8888, 0, 0, 8'h00, 12'h000);

    tbl_a0 = 32'h4444_8888;
    for (int j = 1; j <= 20; j++) begin
      e = tbl_a0[4*((j-1)/4) +: 4];
      edge_chk("f5_pre_drop", e, 1'b0);
    end
    bus.enable = 1'b0;
    bus.mode   = 8'b11_10_01_00;
    bus.phase  = 12'h000;
    edge_chk("drop0", 4'h0, 1'b0);
    edge_chk("drop1", 4'h0, 1'b0);
    edge_chk("drop2", 4'h0, 1'b0);

    bus.enable = 1'b1;
    edge_chk("restart", 4'h0, 1'b1);
    run_frame("f6_restart", 32'h2222_6E6E, 0, 0, 8'h00, 12'h000);
    edge_chk("f7_step0", 4'hE, 1'b0);

    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 4'h0, 1'b0);
    edge_chk("reset_held", 4'h0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
